// File: rtl/cafeteira_pkg.sv
// Shared definitions for the coffee machine sequencer: state encodings,
// error codes and a constant-width helper.
package cafeteira_pkg;

    typedef enum logic [4:0] {
        INICIAL       = 5'd0,
        PREPARA       = 5'd1,
        ESPERA_MODO   = 5'd3,
        ZERA_SENSOR   = 5'd4,
        ATIVA_SENSOR  = 5'd5,
        ESPERA_SENSOR = 5'd6,
        ATIVA_ETAPA   = 5'd12,
        ESPERA_ETAPA  = 5'd13,
        ERRO          = 5'd15,
        FIM           = 5'd17
    } estado_t;

    localparam logic [2:0] COD_NENHUM              = 3'd0;
    localparam logic [2:0] COD_SENSOR_REPROVADO    = 3'd1;
    localparam logic [2:0] COD_SENSOR_SEM_RESPOSTA = 3'd2;
    localparam logic [2:0] COD_TIMEOUT_ETAPA       = 3'd3;
    localparam logic [2:0] COD_CANCELADO           = 3'd4;

    // Bits needed to count 0..valor-1, never less than one.
    function automatic int clog2(input int valor);
        int r;
        r = 0;
        for (int v = valor - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cafeteira_sequenciador_contador_timeout.sv
// Saturating watchdog counter shared by the sensor and stage wait states;
// flags when the count equals the selected limit.
module contador_timeout #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         limpa,
    input  logic         habilita,
    input  logic [W-1:0] limite,
    output logic         expirou
);

    logic [W-1:0] cont_q, cont_d;

    always_comb begin
        cont_d = cont_q;
        if (limpa)
            cont_d = '0;
        else if (habilita && (cont_q != {W{1'b1}}))
            cont_d = cont_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cont_q <= '0;
        else       cont_q <= cont_d;
    end

    assign expirou = (cont_q == limite);

endmodule

// File: rtl/cafeteira_sequenciador.sv
// Coffee machine control unit: sensor pre-checks with retry, then actuator
// stages under a watchdog, with cancel and registered error reporting.
module cafeteira_sequenciador
    import cafeteira_pkg::*;
#(
    parameter int                  N_SENSORES      = 2,
    parameter int                  N_ETAPAS        = 3,
    parameter int                  MAX_TENTATIVAS  = 3,
    parameter int                  TIMEOUT_SENSOR  = 1000,
    parameter int                  TIMEOUT_ETAPA   = 100000,
    parameter logic [N_ETAPAS-1:0] MASCARA_TIMEOUT = N_ETAPAS'(3'b010)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  preparar,
    input  logic                  cancelar,
    input  logic                  pronto_serial,
    input  logic [N_SENSORES-1:0] sensor_pronto,
    input  logic [N_SENSORES-1:0] sensor_ok,
    input  logic [N_ETAPAS-1:0]   etapa_fim,
    output logic                  zera_serial,
    output logic [N_SENSORES-1:0] zera_sensor,
    output logic [N_SENSORES-1:0] mede_sensor,
    output logic [N_ETAPAS-1:0]   zera_etapa,
    output logic [N_ETAPAS-1:0]   liga_etapa,
    output logic                  ocupado,
    output logic                  concluido,
    output logic                  erro,
    output logic [2:0]            codigo_erro,
    output logic [2:0]            erro_indice,
    output logic [4:0]            db_estado,
    output logic [2:0]            db_indice
);

    localparam int WD_W   = clog2((TIMEOUT_SENSOR > TIMEOUT_ETAPA) ? TIMEOUT_SENSOR : TIMEOUT_ETAPA);
    localparam int TENT_W = clog2(MAX_TENTATIVAS + 1);
    localparam logic [WD_W-1:0] LIM_SENSOR = WD_W'(TIMEOUT_SENSOR - 1);
    localparam logic [WD_W-1:0] LIM_ETAPA  = WD_W'(TIMEOUT_ETAPA - 1);

    estado_t           estado_q, estado_d;
    logic [2:0]        idx_q, idx_d;
    logic [TENT_W-1:0] tent_q, tent_d;
    logic [2:0]        cod_q, cod_d;
    logic [2:0]        ind_q, ind_d;

    logic            wd_limpa, wd_habilita, wd_expirou;
    logic [WD_W-1:0] wd_limite;

    logic                  pronto_sel, ok_sel, fim_sel, mascara_sel;
    logic [N_SENSORES-1:0] oh_sensor;
    logic [N_ETAPAS-1:0]   oh_etapa;
    logic                  ultimo_sensor, ultima_etapa, ultima_tentativa;

    // Select the current index by compare rather than by variable bit-select
    // so a 3-bit idx never reaches past the narrower vectors.
    always_comb begin
        pronto_sel = 1'b0;
        ok_sel     = 1'b0;
        oh_sensor  = '0;
        for (int i = 0; i < N_SENSORES; i++) begin
            if (idx_q == 3'(i)) begin
                pronto_sel   = sensor_pronto[i];
                ok_sel       = sensor_ok[i];
                oh_sensor[i] = 1'b1;
            end
        end
    end

    always_comb begin
        fim_sel     = 1'b0;
        mascara_sel = 1'b0;
        oh_etapa    = '0;
        for (int j = 0; j < N_ETAPAS; j++) begin
            if (idx_q == 3'(j)) begin
                fim_sel     = etapa_fim[j];
                mascara_sel = MASCARA_TIMEOUT[j];
                oh_etapa[j] = 1'b1;
            end
        end
    end

    assign ultimo_sensor    = (idx_q == 3'(N_SENSORES - 1));
    assign ultima_etapa     = (idx_q == 3'(N_ETAPAS - 1));
    assign ultima_tentativa = ((int'(tent_q) + 1) == MAX_TENTATIVAS);

    contador_timeout #(.W(WD_W)) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .limpa    (wd_limpa),
        .habilita (wd_habilita),
        .limite   (wd_limite),
        .expirou  (wd_expirou)
    );

    always_comb begin
        estado_d    = estado_q;
        idx_d       = idx_q;
        tent_d      = tent_q;
        cod_d       = cod_q;
        ind_d       = ind_q;
        wd_limpa    = 1'b0;
        wd_habilita = 1'b0;
        wd_limite   = LIM_SENSOR;
        case (estado_q)
            INICIAL: if (preparar) estado_d = PREPARA;
            PREPARA: begin
                cod_d    = COD_NENHUM;
                ind_d    = '0;
                idx_d    = '0;
                tent_d   = '0;
                estado_d = ESPERA_MODO;
            end
            ESPERA_MODO: if (pronto_serial) estado_d = ZERA_SENSOR;
            ZERA_SENSOR: begin
                wd_limpa = 1'b1;
                estado_d = ATIVA_SENSOR;
            end
            ATIVA_SENSOR: estado_d = ESPERA_SENSOR;
            ESPERA_SENSOR: begin
                wd_habilita = 1'b1;
                if (pronto_sel) begin
                    if (!ok_sel) begin
                        estado_d = ERRO;
                        cod_d    = COD_SENSOR_REPROVADO;
                        ind_d    = idx_q;
                    end else if (ultimo_sensor) begin
                        idx_d    = '0;
                        estado_d = ATIVA_ETAPA;
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        tent_d   = '0;
                        estado_d = ZERA_SENSOR;
                    end
                end else if (wd_expirou) begin
                    if (ultima_tentativa) begin
                        estado_d = ERRO;
                        cod_d    = COD_SENSOR_SEM_RESPOSTA;
                        ind_d    = idx_q;
                    end else begin
                        tent_d   = tent_q + 1'b1;
                        estado_d = ZERA_SENSOR;
                    end
                end
            end
            ATIVA_ETAPA: begin
                wd_limpa = 1'b1;
                estado_d = ESPERA_ETAPA;
            end
            ESPERA_ETAPA: begin
                wd_habilita = 1'b1;
                wd_limite   = LIM_ETAPA;
                if (fim_sel) begin
                    if (ultima_etapa) begin
                        estado_d = FIM;
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        estado_d = ATIVA_ETAPA;
                    end
                end else if (mascara_sel && wd_expirou) begin
                    estado_d = ERRO;
                    cod_d    = COD_TIMEOUT_ETAPA;
                    ind_d    = idx_q;
                end
            end
            ERRO:    estado_d = INICIAL;
            FIM:     estado_d = INICIAL;
            default: estado_d = INICIAL;
        endcase

        // Cancel wins over everything else decided above in this cycle.
        if (cancelar && !(estado_q inside {INICIAL, ERRO, FIM})) begin
            estado_d = ERRO;
            idx_d    = idx_q;
            tent_d   = tent_q;
            cod_d    = COD_CANCELADO;
            ind_d    = idx_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= INICIAL;
            idx_q    <= '0;
            tent_q   <= '0;
            cod_q    <= COD_NENHUM;
            ind_q    <= '0;
        end else begin
            estado_q <= estado_d;
            idx_q    <= idx_d;
            tent_q   <= tent_d;
            cod_q    <= cod_d;
            ind_q    <= ind_d;
        end
    end

    always_comb begin
        zera_serial = 1'b0;
        zera_sensor = '0;
        mede_sensor = '0;
        zera_etapa  = '0;
        liga_etapa  = '0;
        concluido   = 1'b0;
        erro        = 1'b0;
        case (estado_q)
            PREPARA: begin
                zera_serial = 1'b1;
                zera_sensor = '1;
                zera_etapa  = '1;
            end
            ZERA_SENSOR:  zera_sensor = oh_sensor;
            ATIVA_SENSOR: mede_sensor = oh_sensor;
            ATIVA_ETAPA:  liga_etapa  = oh_etapa;
            ERRO: begin
                erro       = 1'b1;
                zera_etapa = '1;
            end
            FIM:     concluido = 1'b1;
            default: ;
        endcase
    end

    assign ocupado     = (estado_q != INICIAL);
    assign codigo_erro = cod_q;
    assign erro_indice = ind_q;
    assign db_estado   = estado_q;
    assign db_indice   = idx_q;

endmodule

// File: tb/tb_cafeteira_sequenciador.sv
// Randomized bench for cafeteira_sequenciador: a responder plays sensors and
// stages, and an event-timeline model predicts pulse times and error reports.
module tb_cafeteira_sequenciador;

    localparam int NS = 2, NE = 3, MAXT = 2, TS = 8, TE = 16;
    localparam logic [NE-1:0] MASK = 3'b010;

    logic clock = 1'b0, reset = 1'b1, preparar = 1'b0, pronto_serial = 1'b0;
    logic cancelar, cancel_req = 1'b0, cancel_auto = 1'b0;
    logic [NS-1:0] sensor_pronto = '0, sensor_ok = '0;
    logic [NE-1:0] etapa_fim = '0;
    logic zera_serial, ocupado, concluido, erro;
    logic [NS-1:0] zera_sensor, mede_sensor;
    logic [NE-1:0] zera_etapa, liga_etapa;
    logic [2:0] codigo_erro, erro_indice, db_indice;
    logic [4:0] db_estado;

    assign cancelar = cancel_req | cancel_auto;

    cafeteira_sequenciador #(
        .N_SENSORES(NS), .N_ETAPAS(NE), .MAX_TENTATIVAS(MAXT),
        .TIMEOUT_SENSOR(TS), .TIMEOUT_ETAPA(TE), .MASCARA_TIMEOUT(MASK)
    ) dut (
        .clock(clock), .reset(reset), .preparar(preparar), .cancelar(cancelar),
        .pronto_serial(pronto_serial), .sensor_pronto(sensor_pronto), .sensor_ok(sensor_ok),
        .etapa_fim(etapa_fim), .zera_serial(zera_serial), .zera_sensor(zera_sensor),
        .mede_sensor(mede_sensor), .zera_etapa(zera_etapa), .liga_etapa(liga_etapa),
        .ocupado(ocupado), .concluido(concluido), .erro(erro), .codigo_erro(codigo_erro),
        .erro_indice(erro_indice), .db_estado(db_estado), .db_indice(db_indice)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests_run = 0, tests_failed = 0;

    // Scenario configuration: delay 0 means "never answers".
    int d_modo;
    int d_s[NS];
    bit ok_s[NS];
    int d_e[NE];
    int cancel_stage;
    bit stale;

    // Observed event log.
    int lg_zs;
    int lg_mede_t[$];
    logic [NS-1:0] lg_mede_v[$];
    int lg_liga_t[$];
    logic [NE-1:0] lg_liga_v[$];
    int lg_conc_t[$];
    int lg_err_t[$];
    logic [NE-1:0] lg_err_ze[$];

    // Model expectations.
    int exp_mede_t[$];
    logic [NS-1:0] exp_mede_v[$];
    int exp_liga_t[$];
    logic [NE-1:0] exp_liga_v[$];
    int exp_kind, exp_end_t, exp_code, exp_idx;
    int obs_kind, obs_end;

    // Responder and monitor: log what the DUT shows this cycle, then drive inputs.
    initial begin
        int sch_s[NS];
        int sch_e[NE];
        int modo_at;
        bit held[NE];
        modo_at = -1;
        forever begin
            @(negedge clock);
            if (reset) begin
                for (int i = 0; i < NS; i++) sch_s[i] = -1;
                for (int j = 0; j < NE; j++) begin sch_e[j] = -1; held[j] = 1'b0; end
                modo_at = -1;
                sensor_pronto = '0; etapa_fim = '0; pronto_serial = 1'b0; cancel_auto = 1'b0;
            end else begin
                if (zera_serial) begin lg_zs = cyc; modo_at = cyc + d_modo; end
                if (mede_sensor != '0) begin lg_mede_t.push_back(cyc); lg_mede_v.push_back(mede_sensor); end
                if (liga_etapa != '0) begin lg_liga_t.push_back(cyc); lg_liga_v.push_back(liga_etapa); end
                if (concluido) lg_conc_t.push_back(cyc);
                if (erro) begin lg_err_t.push_back(cyc); lg_err_ze.push_back(zera_etapa); end
                pronto_serial = (modo_at >= 0) && (cyc >= modo_at);
                for (int i = 0; i < NS; i++) begin
                    sensor_pronto[i] = (sch_s[i] == cyc);
                    sensor_ok[i]     = (sch_s[i] == cyc) ? ok_s[i] : 1'($urandom);
                    if (mede_sensor[i] && d_s[i] > 0) sch_s[i] = cyc + d_s[i];
                end
                cancel_auto = 1'b0;
                for (int j = 0; j < NE; j++) begin
                    if (zera_etapa[j]) held[j] = 1'b0;
                    etapa_fim[j] = (sch_e[j] == cyc) || (stale && held[j]);
                    if (sch_e[j] == cyc) begin
                        held[j] = 1'b1;
                        if (j == cancel_stage) cancel_auto = 1'b1;
                    end
                    if (liga_etapa[j] && d_e[j] > 0) sch_e[j] = cyc + d_e[j];
                end
            end
        end
    end

    task automatic cfg_default();
        d_modo = 1;
        for (int i = 0; i < NS; i++) begin d_s[i] = 2; ok_s[i] = 1'b1; end
        for (int j = 0; j < NE; j++) d_e[j] = 3;
        cancel_stage = -1;
        stale = 1'b0;
    endtask

    task automatic clear_logs();
        lg_zs = -1;
        lg_mede_t.delete(); lg_mede_v.delete(); lg_liga_t.delete(); lg_liga_v.delete();
        lg_conc_t.delete(); lg_err_t.delete(); lg_err_ze.delete();
    endtask

    // Timeline from the specification's rules, anchored at the PREPARA cycle.
    task automatic model(input int tz);
        int t, m, att;
        logic [NE-1:0] mk;
        mk = MASK;
        exp_mede_t.delete(); exp_mede_v.delete(); exp_liga_t.delete(); exp_liga_v.delete();
        exp_kind = 0; exp_end_t = -1; exp_code = 0; exp_idx = 0;
        t = tz + d_modo + 1;
        for (int i = 0; i < NS; i++) begin
            att = 0;
            forever begin
                m = t + 1;
                exp_mede_t.push_back(m);
                exp_mede_v.push_back(NS'(1) << i);
                if (d_s[i] > 0) begin
                    t = m + d_s[i] + 1;
                    if (!ok_s[i]) begin exp_kind = 2; exp_end_t = t; exp_code = 1; exp_idx = i; return; end
                    break;
                end
                att++;
                t = m + TS + 1;
                if (att == MAXT) begin exp_kind = 2; exp_end_t = t; exp_code = 2; exp_idx = i; return; end
            end
        end
        for (int j = 0; j < NE; j++) begin
            exp_liga_t.push_back(t);
            exp_liga_v.push_back(NE'(1) << j);
            if (j == cancel_stage) begin
                exp_kind = 2; exp_end_t = t + d_e[j] + 1; exp_code = 4; exp_idx = j; return;
            end
            if (d_e[j] > 0) t = t + d_e[j] + 1;
            else if (mk[j]) begin exp_kind = 2; exp_end_t = t + TE + 1; exp_code = 3; exp_idx = j; return; end
            else return;
        end
        exp_kind = 1; exp_end_t = t;
    endtask

    task automatic run_once(input int budget);
        @(posedge clock); #1;
        clear_logs();
        @(negedge clock); preparar = 1'b1;
        @(negedge clock); preparar = 1'b0;
        for (int k = 0; k < budget && lg_conc_t.size() == 0 && lg_err_t.size() == 0; k++) @(negedge clock);
        repeat (3) @(negedge clock);
        obs_kind = (lg_err_t.size() > 0) ? 2 : (lg_conc_t.size() > 0) ? 1 : 0;
        obs_end  = (obs_kind == 2) ? lg_err_t[0] : (obs_kind == 1) ? lg_conc_t[0] : -1;
        model(lg_zs);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests_run++;
        if ({zera_serial, zera_sensor, mede_sensor, zera_etapa, liga_etapa, ocupado, concluido, erro,
             codigo_erro, erro_indice, db_estado, db_indice} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: estado=%0d ocupado=%b codigo=%0d expected all zero", db_estado, ocupado, codigo_erro);
        end
        @(negedge clock); #1 reset = 1'b0;
    endtask

    task automatic test_nominal_random();
        for (int r = 0; r < 6; r++) begin
            int t_start;
            cfg_default();
            if (r > 0) begin
                d_modo = $urandom_range(1, 4);
                for (int i = 0; i < NS; i++) d_s[i] = $urandom_range(1, TS);
                d_e[0] = $urandom_range(1, 12);
                d_e[1] = $urandom_range(1, TE);
                d_e[2] = $urandom_range(1, 12);
                stale  = 1'($urandom);
            end
            t_start = cyc;
            run_once(300);
            tests_run++;
            if (lg_zs != t_start + 2) begin
                tests_failed++; $display("FAIL nominal%0d_prepara_time: got %0d expected %0d", r, lg_zs, t_start + 2);
            end
            tests_run++;
            if (obs_kind != exp_kind || obs_end != exp_end_t) begin
                tests_failed++; $display("FAIL nominal%0d_end: kind %0d at %0d expected kind %0d at %0d", r, obs_kind, obs_end, exp_kind, exp_end_t);
            end
            tests_run++;
            if (lg_mede_t.size() != exp_mede_t.size() || lg_liga_t.size() != exp_liga_t.size()) begin
                tests_failed++; $display("FAIL nominal%0d_pulse_count: mede %0d liga %0d expected %0d %0d", r,
                                         lg_mede_t.size(), lg_liga_t.size(), exp_mede_t.size(), exp_liga_t.size());
            end
            for (int k = 0; k < lg_mede_t.size() && k < exp_mede_t.size(); k++) begin
                tests_run++;
                if (lg_mede_t[k] != exp_mede_t[k] || lg_mede_v[k] !== exp_mede_v[k]) begin
                    tests_failed++; $display("FAIL nominal%0d_mede%0d: %b at %0d expected %b at %0d", r, k,
                                             lg_mede_v[k], lg_mede_t[k], exp_mede_v[k], exp_mede_t[k]);
                end
            end
            for (int k = 0; k < lg_liga_t.size() && k < exp_liga_t.size(); k++) begin
                tests_run++;
                if (lg_liga_t[k] != exp_liga_t[k] || lg_liga_v[k] !== exp_liga_v[k]) begin
                    tests_failed++; $display("FAIL nominal%0d_liga%0d: %b at %0d expected %b at %0d", r, k,
                                             lg_liga_v[k], lg_liga_t[k], exp_liga_v[k], exp_liga_t[k]);
                end
            end
            tests_run++;
            if (lg_conc_t.size() != 1 || codigo_erro !== 3'd0 || ocupado !== 1'b0) begin
                tests_failed++; $display("FAIL nominal%0d_done: concluido pulses %0d codigo %0d ocupado %b expected 1 0 0", r,
                                         lg_conc_t.size(), codigo_erro, ocupado);
            end
        end
    endtask

    task automatic test_sensor_silent();
        cfg_default();
        d_s[0] = 0;
        run_once(300);
        tests_run++;
        if (obs_kind != 2 || obs_end != exp_end_t) begin
            tests_failed++; $display("FAIL silent_end: kind %0d at %0d expected 2 at %0d", obs_kind, obs_end, exp_end_t);
        end
        tests_run++;
        if (lg_mede_t.size() != 2 || (lg_mede_t.size() == 2 && lg_mede_t[1] - lg_mede_t[0] != TS + 2)) begin
            tests_failed++; $display("FAIL silent_retry: %0d mede pulses, expected 2 spaced %0d", lg_mede_t.size(), TS + 2);
        end
        tests_run++;
        if (codigo_erro !== 3'(exp_code) || erro_indice !== 3'(exp_idx)) begin
            tests_failed++; $display("FAIL silent_code: code %0d idx %0d expected %0d %0d", codigo_erro, erro_indice, exp_code, exp_idx);
        end
        tests_run++;
        if (lg_err_ze.size() != 1 || lg_err_ze[0] !== 3'b111) begin
            tests_failed++; $display("FAIL silent_shutdown: erro pulses %0d zera_etapa not 111", lg_err_ze.size());
        end
    endtask

    task automatic test_sensor_fail();
        cfg_default();
        ok_s[1] = 1'b0;
        run_once(300);
        tests_run++;
        if (obs_kind != 2 || obs_end != exp_end_t || codigo_erro !== 3'd1 || erro_indice !== 3'd1) begin
            tests_failed++; $display("FAIL sensor_fail: kind %0d at %0d code %0d idx %0d expected 2 at %0d code 1 idx 1",
                                     obs_kind, obs_end, codigo_erro, erro_indice, exp_end_t);
        end
        tests_run++;
        if (lg_liga_t.size() != 0) begin
            tests_failed++; $display("FAIL sensor_fail_no_liga: got %0d liga pulses expected 0", lg_liga_t.size());
        end
    endtask

    task automatic test_stage_timeout();
        cfg_default();
        d_e[1] = 0;
        run_once(300);
        tests_run++;
        if (obs_kind != 2 || obs_end != exp_end_t || lg_liga_t.size() != 2) begin
            tests_failed++; $display("FAIL stage_timeout_end: kind %0d at %0d liga %0d expected 2 at %0d liga 2",
                                     obs_kind, obs_end, lg_liga_t.size(), exp_end_t);
        end else begin
            tests_run++;
            if (obs_end - lg_liga_t[1] != TE + 1) begin
                tests_failed++; $display("FAIL stage_timeout_delay: got %0d expected %0d", obs_end - lg_liga_t[1], TE + 1);
            end
        end
        tests_run++;
        if (codigo_erro !== 3'd3 || erro_indice !== 3'd1) begin
            tests_failed++; $display("FAIL stage_timeout_code: code %0d idx %0d expected 3 1", codigo_erro, erro_indice);
        end
    endtask

    task automatic test_masked_cancel();
        int tc;
        cfg_default();
        d_e[0] = 0;
        run_once(80);
        tests_run++;
        if (obs_kind != 0 || ocupado !== 1'b1 || db_estado !== 5'd13 || db_indice !== 3'd0) begin
            tests_failed++; $display("FAIL masked_wait: kind %0d ocupado %b estado %0d idx %0d expected 0 1 13 0",
                                     obs_kind, ocupado, db_estado, db_indice);
        end
        tc = cyc;
        cancel_req = 1'b1;
        @(negedge clock); cancel_req = 1'b0;
        repeat (3) @(negedge clock);
        tests_run++;
        if (lg_err_t.size() != 1 || (lg_err_t.size() == 1 && lg_err_t[0] != tc + 1) ||
            codigo_erro !== 3'd4 || erro_indice !== 3'd0) begin
            tests_failed++; $display("FAIL masked_cancel: erro pulses %0d code %0d idx %0d expected 1 at %0d code 4 idx 0",
                                     lg_err_t.size(), codigo_erro, erro_indice, tc + 1);
        end
    endtask

    task automatic test_cancel_fim();
        cfg_default();
        d_e[2] = $urandom_range(1, 6);
        cancel_stage = 2;
        run_once(300);
        tests_run++;
        if (obs_kind != 2 || obs_end != exp_end_t || lg_conc_t.size() != 0) begin
            tests_failed++; $display("FAIL cancel_fim_end: kind %0d at %0d concluido %0d expected 2 at %0d concluido 0",
                                     obs_kind, obs_end, lg_conc_t.size(), exp_end_t);
        end
        tests_run++;
        if (codigo_erro !== 3'd4 || erro_indice !== 3'd2) begin
            tests_failed++; $display("FAIL cancel_fim_code: code %0d idx %0d expected 4 2", codigo_erro, erro_indice);
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        cfg_default();
        d_s[0] = 0;
        @(posedge clock); #1; clear_logs();
        @(negedge clock); preparar = 1'b1;
        @(negedge clock); preparar = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 30 && !hit; k++) begin
            @(negedge clock);
            hit = (db_estado == 5'd6);
        end
        tests_run++;
        if (!hit) begin
            tests_failed++; $display("FAIL reset_mid_reach: estado %0d expected 6 within 30 cycles", db_estado);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({zera_serial, zera_sensor, mede_sensor, zera_etapa, liga_etapa, ocupado, concluido, erro,
             codigo_erro, erro_indice, db_estado, db_indice} !== '0) begin
            tests_failed++; $display("FAIL reset_mid_async: estado %0d ocupado %b expected all zero before edge", db_estado, ocupado);
        end
        @(negedge clock); #1 reset = 1'b0;
        cfg_default();
        run_once(300);
        tests_run++;
        if (obs_kind != 1 || obs_end != exp_end_t || codigo_erro !== 3'd0 || erro_indice !== 3'd0) begin
            tests_failed++; $display("FAIL reset_mid_restart: kind %0d at %0d code %0d expected 1 at %0d code 0",
                                     obs_kind, obs_end, codigo_erro, exp_end_t);
        end
    endtask

    initial begin
        cfg_default();
        clear_logs();
        test_reset();
        test_nominal_random();
        test_sensor_silent();
        test_sensor_fail();
        test_stage_timeout();
        test_masked_cancel();
        test_cancel_fim();
        test_nominal_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
